uart_byte_receiver: RTL and testbench
=====================================

// Module: uart_byte_receiver
// PURPOSE
// - 8N1 UART receiver (8O/E1 with the optional feature) for the wireless IMU link.
// - Oversamples the raw rx pin and majority-votes each bit.
// - Emits a one-cycle next_byte strobe with data valid in that same cycle.
// - Sits directly upstream of the packet parser, which consumes next_byte/data.
// PARAMETERS
// - CLK_FREQ    100_000_000  system clock frequency, Hz
// - BAUD        115200       line rate, bit/s
// - OVERSAMPLE  16           sample ticks per bit; must be >= 8 and even
// - DIV (localparam) = (CLK_FREQ + BAUD*OVERSAMPLE/2) / (BAUD*OVERSAMPLE); clk cycles per tick
// PORTS
// - clk           in   1  system clock, all logic on posedge
// - rst           in   1  synchronous, active-high reset
// - rx            in   1  asynchronous serial input; idle high
// - next_byte     out  1  one-cycle strobe: a valid byte was received
// - data          out  8  last received byte, LSB received first; held between strobes
// - frame_error   out  1  one-cycle strobe: stop bit sampled low
// - parity_error  out  1  one-cycle strobe: parity mismatch; port exists only with UART_RX_PARITY_EN
// BEHAVIOUR
// - Reset values: next_byte=0, data=8'h00, frame_error=0, parity_error=0, state=IDLE.
//   Reset also sets sync flops to 1 and clears the tick divider, sample counter, bit counter and shift register.
// - rst mid-frame: the partial byte is discarded; no strobe is produced for it.
// - Input sync: 2-flop synchronizer on rx. rx_s is the second flop. All decisions use rx_s.
// - Tick generator: counter 0..DIV-1, free-running. tick=1 for one clk when it wraps.
//   Resets to 0 on entry to START so the mid-bit phase is aligned to the falling edge.
// - Sample counter sc counts 0..OVERSAMPLE-1 per bit, advancing on tick.
// - Bit value = majority of rx_s at sc = M-1, M, M+1, where M = OVERSAMPLE/2.
//   The bit decision is taken at sc = M+1.
// - State machine:
//   IDLE: rx_s==0 (checked every clk) -> START, with sc=0.
//   START: at the decision point, majority 0 -> DATA (bit counter=0); majority 1 -> IDLE (glitch reject).
//   DATA: at each decision point, shift the bit in LSB-first and increment the bit counter.
//     After bit 7 -> PARITY if macro is defined, else STOP.
//     At sc=OVERSAMPLE-1 with tick, sc wraps to 0 for the next bit.
//   PARITY: decision compared against the expected parity; mismatch latched internally.
//   STOP: at the decision point:
//     majority 1 and no parity mismatch -> data<=shift, next_byte=1 for 1 clk, -> IDLE.
//     majority 1 and parity mismatch -> parity_error=1 for 1 clk, data unchanged, -> IDLE.
//     majority 0 -> frame_error=1 for 1 clk, data unchanged, -> BREAK.
//   BREAK: wait until rx_s==1, then -> IDLE (no false start while the line is held low).
// - Returning to IDLE at mid-stop-bit allows back-to-back frames with zero idle time.
// - Latency: the strobe is asserted the clk after the stop-bit decision tick.
//   That is about 9.5 bit times (10.5 with parity) + 2 sync cycles after the start falling edge.
// - Strobes are mutually exclusive; at most one strobe per frame.
// - Tolerance: works with a combined baud error of up to +/-3 %.
// CONFIGURATION
// - UART_RX_PARITY_EN defined:
//   - A parity bit is expected between bit 7 and the stop bit.
//   - Localparam PARITY_ODD=0 selects even parity.
//   - The parity_error port is present.
//   - A frame that fails parity but has a good stop bit gives parity_error, not next_byte.
//   - If the stop bit is low, frame_error takes priority over parity_error.
// - UART_RX_PARITY_EN undefined: 8N1 only. No PARITY state and no parity_error port.
// TESTING (bench: CLK_FREQ=1_600_000, BAUD=10_000, OVERSAMPLE=16 -> DIV=10, 160 clk/bit)
// - Test 1, single byte: idle high, send 0x55 8N1.
//   -> Exactly one next_byte pulse, data=0x55, frame_error never asserted.
// - Test 2, back-to-back: send 0x55 then 0x51, with the next start bit immediately after the stop bit.
//   -> Two pulses, with data 0x55 then 0x51.
// - Test 3, glitch: rx low for 30 clk, then high.
//   -> No strobe; the receiver returns to IDLE. A following 0x53 is received correctly.
// - Test 4, framing error: send 0xA5 with the stop bit low, hold low 2 bits, then high for 1 bit, then send 0x3C.
//   -> One frame_error pulse, no next_byte, data stays at the previous value.
//   -> Then next_byte with data=0x3C.
// - Test 5, reset mid-frame: assert rst for 1 clk after 4 data bits of 0x0F; then idle 1 bit and send 0x53.
//   -> No strobe for 0x0F, data=0x00 after reset, then next_byte with data=0x53.
// - Test 6, parity (UART_RX_PARITY_EN): send 0x51 with parity bit 0 (wrong; even parity expects 1).
//   -> One parity_error pulse, no next_byte.
//   -> 0x51 sent with parity bit 1 then gives next_byte with data=0x51.

Source files
------------

// File: rtl/uart_byte_receiver.sv
// uart_byte_receiver
// Oversampling UART receiver for the wireless IMU link. The raw rx pin is
// synchronized, sampled OVERSAMPLE times per bit and each bit is decided by a
// 3-sample majority vote around mid-bit. A good frame produces a one-cycle
// next_byte strobe with data valid in the same cycle; data holds its value
// until the next good frame.
//
// Build option: define UART_RX_PARITY_EN to expect a parity bit between
// bit 7 and the stop bit (even parity, PARITY_ODD=0). This also adds the
// parity_error strobe port. Without the macro the receiver is 8N1 only.
//
// OVERSAMPLE must be at least 8 and even.

module uart_byte_receiver #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       next_byte,
    output logic [7:0] data,
`ifdef UART_RX_PARITY_EN
    output logic       frame_error,
    output logic       parity_error
`else
    output logic       frame_error
`endif
);

    // ------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------
    // Clock cycles per oversample tick, rounded to nearest.
    localparam int DIV   = (CLK_FREQ + BAUD * OVERSAMPLE / 2) / (BAUD * OVERSAMPLE);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SC_W  = $clog2(OVERSAMPLE);
    localparam int MID   = OVERSAMPLE / 2;

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [SC_W-1:0]  SC_LAST   = SC_W'(OVERSAMPLE - 1);
    localparam logic [SC_W-1:0]  SC_VOTE_A = SC_W'(MID - 1);
    localparam logic [SC_W-1:0]  SC_VOTE_B = SC_W'(MID);
    localparam logic [SC_W-1:0]  SC_DECIDE = SC_W'(MID + 1);

`ifdef UART_RX_PARITY_EN
    // 0 = even parity, 1 = odd parity.
    localparam logic PARITY_ODD = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        BREAK
    } state_t;

    // ------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------
    state_t            state;
    state_t            state_nxt;

    logic              rx_meta;
    logic              rx_s;

    logic [DIV_W-1:0]  div_cnt;
    logic              tick;
    logic [SC_W-1:0]   sc;

    logic              vote_a;
    logic              vote_b;
    logic              vote;
    logic              decide;

    logic [2:0]        bit_cnt;
    logic [7:0]        shift;

    // Control strobes from the FSM to the datapath.
    logic              start_entry;
    logic              bit_clr;
    logic              shift_en;
    logic              byte_ok;
    logic              ferr_set;
`ifdef UART_RX_PARITY_EN
    logic              par_chk;
    logic              par_mismatch;
    logic              perr_set;
`endif

    // ------------------------------------------------------------------
    // Input synchronizer
    // ------------------------------------------------------------------
    // Two-flop synchronizer on the asynchronous rx pin; the line idles high.
    always_ff @(posedge clk) begin
        // NOTE: sequential state is written with <= so each flop captures the
        // pre-edge value of its source; with = the two stages would collapse
        // into a single flop and the metastability filter would be lost.
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // ------------------------------------------------------------------
    // Tick generator and sample counter
    // ------------------------------------------------------------------
    assign tick   = (div_cnt == DIV_LAST);
    assign decide = tick && (sc == SC_DECIDE);

    // Free-running tick divider, re-phased to the falling edge of a start bit.
    always_ff @(posedge clk) begin
        if (rst || start_entry) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    // Per-bit sample counter; it runs across bit boundaries so every bit's
    // decision point sits the same distance after its nominal start.
    always_ff @(posedge clk) begin
        if (rst || start_entry) begin
            sc <= '0;
        end else if (tick) begin
            if (sc == SC_LAST) begin
                sc <= '0;
            end else begin
                sc <= sc + SC_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Majority vote
    // ------------------------------------------------------------------
    // Capture the two early samples; the third is rx_s at the decision tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            vote_a <= 1'b1;
            vote_b <= 1'b1;
        end else if (tick) begin
            if (sc == SC_VOTE_A) begin
                vote_a <= rx_s;
            end
            if (sc == SC_VOTE_B) begin
                vote_b <= rx_s;
            end
        end
    end

    assign vote = (vote_a & vote_b) | (vote_a & rx_s) | (vote_b & rx_s);

    // ------------------------------------------------------------------
    // Frame state machine
    // ------------------------------------------------------------------
    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and control decode; every decision waits for the mid-bit vote.
    always_comb begin
        // NOTE: every signal written here gets a default before the case, so
        // no path leaves one unassigned and no latch is inferred.
        state_nxt   = state;
        start_entry = 1'b0;
        bit_clr     = 1'b0;
        shift_en    = 1'b0;
        byte_ok     = 1'b0;
        ferr_set    = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_chk     = 1'b0;
        perr_set    = 1'b0;
`endif
        unique case (state)
            IDLE: begin
                if (!rx_s) begin
                    start_entry = 1'b1;
                    state_nxt   = START;
                end
            end
            START: begin
                if (decide) begin
                    if (vote) begin
                        // Start bit did not hold low through mid-bit: glitch.
                        state_nxt = IDLE;
                    end else begin
                        bit_clr   = 1'b1;
                        state_nxt = DATA;
                    end
                end
            end
            DATA: begin
                if (decide) begin
                    shift_en = 1'b1;
                    if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_nxt = PARITY;
`else
                        state_nxt = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (decide) begin
                    par_chk   = 1'b1;
                    state_nxt = STOP;
                end
            end
`endif
            STOP: begin
                if (decide) begin
                    if (!vote) begin
                        // Stop bit low: framing error wins over parity.
                        ferr_set  = 1'b1;
                        state_nxt = BREAK;
                    end else begin
`ifdef UART_RX_PARITY_EN
                        if (par_mismatch) begin
                            perr_set = 1'b1;
                        end else begin
                            byte_ok = 1'b1;
                        end
`else
                        byte_ok = 1'b1;
`endif
                        // Leaving at mid-stop-bit lets the next start edge
                        // follow the stop bit with no idle time.
                        state_nxt = IDLE;
                    end
                end
            end
            BREAK: begin
                // Hold off until the line is released so a long low level
                // cannot be mistaken for a new start bit.
                if (rx_s) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Data path
    // ------------------------------------------------------------------
    // Bit counter for the eight data bits.
    always_ff @(posedge clk) begin
        if (rst || bit_clr) begin
            bit_cnt <= 3'd0;
        end else if (shift_en) begin
            bit_cnt <= bit_cnt + 3'd1;
        end
    end

    // LSB-first shift register: the first data bit ends up in bit 0.
    always_ff @(posedge clk) begin
        // NOTE: this register only reaches data on a good frame, but it is
        // still reset explicitly so no X can ever propagate into data.
        if (rst) begin
            shift <= 8'h00;
        end else if (shift_en) begin
            shift <= {vote, shift[7:1]};
        end
    end

`ifdef UART_RX_PARITY_EN
    // Latch a parity mismatch; cleared at every new start edge.
    always_ff @(posedge clk) begin
        if (rst || start_entry) begin
            par_mismatch <= 1'b0;
        end else if (par_chk) begin
            par_mismatch <= (vote != ((^shift) ^ PARITY_ODD));
        end
    end
`endif

    // Registered outputs: strobes last one clk, data holds between good frames.
    always_ff @(posedge clk) begin
        if (rst) begin
            next_byte   <= 1'b0;
            frame_error <= 1'b0;
            data        <= 8'h00;
`ifdef UART_RX_PARITY_EN
            parity_error <= 1'b0;
`endif
        end else begin
            next_byte   <= byte_ok;
            frame_error <= ferr_set;
`ifdef UART_RX_PARITY_EN
            parity_error <= perr_set;
`endif
            if (byte_ok) begin
                data <= shift;
            end
        end
    end

endmodule

// File: tb/tb_uart_byte_receiver.sv
// tb_uart_byte_receiver
// Directed bench for uart_byte_receiver at 160 clk per bit (DIV=10).
// A table of good frames is applied in a loop; glitch, framing error,
// mid-frame reset and (with UART_RX_PARITY_EN) parity cases are hand-written.

module tb_uart_byte_receiver;

    localparam int CLK_FREQ   = 1_600_000;
    localparam int BAUD       = 10_000;
    localparam int OVERSAMPLE = 16;
    localparam int BIT_CLKS   = 160;

    // Start-bit negedge to strobe-visible negedge: 2 sync flops + 1 detect
    // edge, then the stop-bit decision on tick number 10 + 16*9 (10 clk each),
    // then one registered output stage that lands on the same edge count.
`ifdef UART_RX_PARITY_EN
    localparam int LATENCY = 3 + 10 * (10 + 16 * 10);
`else
    localparam int LATENCY = 3 + 10 * (10 + 16 * 9);
`endif

    logic       clk;
    logic       rst;
    logic       rx;
    logic       next_byte;
    logic [7:0] data;
    logic       frame_error;
`ifdef UART_RX_PARITY_EN
    logic       parity_error;
`endif

    uart_byte_receiver #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .OVERSAMPLE (OVERSAMPLE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rx           (rx),
        .next_byte    (next_byte),
        .data         (data),
`ifdef UART_RX_PARITY_EN
        .frame_error  (frame_error),
        .parity_error (parity_error)
`else
        .frame_error  (frame_error)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bookkeeping
    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    int         nb_cnt   = 0;
    int         fe_cnt   = 0;
    int         pe_cnt   = 0;
    int         nb_cyc   = 0;
    int         start_cyc = 0;
    logic [7:0] nb_data  = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Strobe monitor, sampled on the falling edge.
    always @(negedge clk) begin
        int n_strobes;
        n_strobes = int'(next_byte) + int'(frame_error);
`ifdef UART_RX_PARITY_EN
        n_strobes = n_strobes + int'(parity_error);
        if (parity_error) pe_cnt = pe_cnt + 1;
`endif
        if (next_byte) begin
            nb_cnt  = nb_cnt + 1;
            nb_data = data;
            nb_cyc  = cyc;
        end
        if (frame_error) fe_cnt = fe_cnt + 1;
        if (n_strobes != 0) check("strobe_exclusive", n_strobes, 1);
    end

    // Watchdog: the run is a fixed schedule well under this bound.
    initial begin
        repeat (90_000) @(posedge clk);
        $display("FAIL watchdog: run exceeded %0d cycles", 90_000);
        $fatal(1, "watchdog expired");
    end

    task automatic send_bit(input logic b);
        rx = b;
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    task automatic idle_bits(input int n);
        rx = 1'b1;
        repeat (n * BIT_CLKS) @(negedge clk);
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic send_frame_par(input logic [7:0] b, input logic par, input logic stop);
        start_cyc = cyc;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(par);
        send_bit(stop);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        send_frame_par(b, ^b, stop);
    endtask
`else
    task automatic send_frame(input logic [7:0] b, input logic stop);
        start_cyc = cyc;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop);
    endtask
`endif

    typedef struct {
        logic [7:0] payload;
        int         gap_bits;
        int         exp_bytes;
        logic [7:0] exp_data;
        int         exp_ferr;
    } vec_t;

    localparam int NVEC = 8;
    vec_t vecs [NVEC];

    int nb0, fe0, pe0;

    initial begin
        // Good frames; gap 0 means the next start bit follows the stop bit.
        vecs[0] = '{8'h55, 2, 1, 8'h55, 0};
        vecs[1] = '{8'h55, 0, 1, 8'h55, 0};
        vecs[2] = '{8'h51, 1, 1, 8'h51, 0};
        vecs[3] = '{8'h00, 1, 1, 8'h00, 0};
        vecs[4] = '{8'hFF, 0, 1, 8'hFF, 0};
        vecs[5] = '{8'h80, 0, 1, 8'h80, 0};
        vecs[6] = '{8'h01, 1, 1, 8'h01, 0};
        vecs[7] = '{8'h51, 1, 1, 8'h51, 0};

        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_next_byte",   32'(next_byte),   32'd0);
        check("reset_data",        32'(data),        32'h00);
        check("reset_frame_error", 32'(frame_error), 32'd0);
        rst = 1'b0;
        idle_bits(1);

        // Table of good frames
        for (int i = 0; i < NVEC; i++) begin
            nb0 = nb_cnt;
            fe0 = fe_cnt;
            send_frame(vecs[i].payload, 1'b1);
            check($sformatf("vec%0d_strobes", i), nb_cnt - nb0, vecs[i].exp_bytes);
            check($sformatf("vec%0d_data", i), 32'(nb_data), 32'(vecs[i].exp_data));
            check($sformatf("vec%0d_ferr", i), fe_cnt - fe0, vecs[i].exp_ferr);
            check($sformatf("vec%0d_latency", i), nb_cyc - start_cyc, LATENCY);
            if (vecs[i].gap_bits > 0) idle_bits(vecs[i].gap_bits);
        end
        check("data_held", 32'(data), 32'h51);

        // Glitch: 30 clk low pulse is rejected at the start-bit vote
        nb0 = nb_cnt;
        fe0 = fe_cnt;
        rx = 1'b0;
        repeat (30) @(negedge clk);
        idle_bits(2);
        check("glitch_no_byte", nb_cnt - nb0, 0);
        check("glitch_no_ferr", fe_cnt - fe0, 0);
        check("glitch_data_held", 32'(data), 32'h51);
        nb0 = nb_cnt;
        send_frame(8'h53, 1'b1);
        idle_bits(1);
        check("after_glitch_byte", nb_cnt - nb0, 1);
        check("after_glitch_data", 32'(nb_data), 32'h53);

        // Framing error: stop low, line held low 2 more bits, then high 1 bit
        nb0 = nb_cnt;
        fe0 = fe_cnt;
        send_frame(8'hA5, 1'b0);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        check("ferr_pulse", fe_cnt - fe0, 1);
        check("ferr_no_byte", nb_cnt - nb0, 0);
        check("ferr_data_held", 32'(data), 32'h53);
        nb0 = nb_cnt;
        fe0 = fe_cnt;
        send_frame(8'h3C, 1'b1);
        idle_bits(1);
        check("after_ferr_byte", nb_cnt - nb0, 1);
        check("after_ferr_data", 32'(nb_data), 32'h3C);
        check("after_ferr_no_ferr", fe_cnt - fe0, 0);

        // Reset after 4 data bits of 0x0F
        nb0 = nb_cnt;
        fe0 = fe_cnt;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        rx  = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_data", 32'(data), 32'h00);
        check("midrst_next_byte", 32'(next_byte), 32'd0);
        idle_bits(1);
        check("midrst_no_byte", nb_cnt - nb0, 0);
        check("midrst_no_ferr", fe_cnt - fe0, 0);
        send_frame(8'h53, 1'b1);
        idle_bits(1);
        check("after_rst_byte", nb_cnt - nb0, 1);
        check("after_rst_data", 32'(nb_data), 32'h53);

`ifdef UART_RX_PARITY_EN
        // Wrong parity (0 for 0x51, even parity expects 1)
        nb0 = nb_cnt;
        fe0 = fe_cnt;
        pe0 = pe_cnt;
        send_frame_par(8'h51, 1'b0, 1'b1);
        idle_bits(1);
        check("perr_pulse", pe_cnt - pe0, 1);
        check("perr_no_byte", nb_cnt - nb0, 0);
        check("perr_data_held", 32'(data), 32'h53);
        nb0 = nb_cnt;
        send_frame_par(8'h51, 1'b1, 1'b1);
        idle_bits(1);
        check("good_par_byte", nb_cnt - nb0, 1);
        check("good_par_data", 32'(nb_data), 32'h51);
        // Bad parity and bad stop: framing error takes priority
        pe0 = pe_cnt;
        fe0 = fe_cnt;
        send_frame_par(8'h51, 1'b0, 1'b0);
        idle_bits(1);
        check("prio_ferr", fe_cnt - fe0, 1);
        check("prio_no_perr", pe_cnt - pe0, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
